spi_word_receiver: RTL and testbench

SPI_WORD_RECEIVER -- requirements
Module: spi_word_receiver

---
 rtl/spi_word_receiver.sv | 145 ++++++++++++++
 tb/tb_spi_word_receiver.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/spi_word_receiver.sv
// SPI slave word receiver: synchronizes cs/spiClk/sdi onto clk, assembles DATA_W-bit
// words and queues them in a small FIFO with sticky overrun and framing-error flags.
module spi_word_receiver #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 1,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0
) (
  input  logic                          clk,
  input  logic                          nRst,
  input  logic                          cs,
  input  logic                          spiClk,
  input  logic                          sdi,
  output logic [DATA_W-1:0]             outData,
  output logic                          outValid,
  input  logic                          outReady,
  output logic                          overrun,
  output logic                          frameErr,
  input  logic                          clrFlags,
  output logic [$clog2(FIFO_DEPTH):0]   fillLevel
);

  localparam int   AW        = $clog2(FIFO_DEPTH);
  localparam int   CW        = $clog2(DATA_W + 1);
  localparam logic CK_IDLE   = (CPOL != 0);
  localparam logic RISE_SAMP = (CPOL == CPHA);

  typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

  state_t            r_state, w_next;
  logic              r_csS1, r_csS2, r_csH;
  logic              r_ckS1, r_ckS2, r_ckH;
  logic              r_sdS1, r_sdS2, r_sdH;
  logic [1:0]        r_settle;
  logic              r_armed;
  logic [CW-1:0]     r_bitCnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_overrun, r_frameErr;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wPtr, r_rPtr;

  logic w_ckEdge, w_sample, w_lastBit, w_setFe;
  logic w_empty, w_full, w_pop, w_pushReq, w_push, w_setOv;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_csS1 <= 1'b0;    r_csS2 <= 1'b0;    r_csH <= 1'b0;
      r_ckS1 <= CK_IDLE; r_ckS2 <= CK_IDLE; r_ckH <= CK_IDLE;
      r_sdS1 <= 1'b0;    r_sdS2 <= 1'b0;    r_sdH <= 1'b0;
    end else begin
      r_csS1 <= cs;     r_csS2 <= r_csS1; r_csH <= r_csS2;
      r_ckS1 <= spiClk; r_ckS2 <= r_ckS1; r_ckH <= r_ckS2;
      r_sdS1 <= sdi;    r_sdS2 <= r_sdS1; r_sdH <= r_sdS2;
    end
  end

  // A frame may only start once cs has been seen low after the synchronizer
  // has flushed its reset values, so a transfer straddling reset is ignored.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_settle <= '0;
      r_armed  <= 1'b0;
    end else begin
      if (r_settle != 2'd3)
        r_settle <= r_settle + 2'd1;
      if (r_settle >= 2'd2 && !r_csS2)
        r_armed <= 1'b1;
    end
  end

  assign w_ckEdge  = RISE_SAMP ? (r_ckS2 & ~r_ckH) : (~r_ckS2 & r_ckH);
  assign w_sample  = w_ckEdge & r_csS2 & (r_state == SHIFT);
  assign w_lastBit = w_sample && (r_bitCnt == CW'(DATA_W - 1));
  assign w_setFe   = (r_state == SHIFT) && !r_csS2 && (r_bitCnt != '0);

  always_ff @(posedge clk) begin
    if (!nRst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!r_csS2) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (r_armed) w_next = SHIFT;
        SHIFT:   if (w_lastBit) w_next = PUSH;
        PUSH:    w_next = SHIFT;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_bitCnt <= '0;
      r_shift  <= '0;
    end else if (!r_csS2) begin
      r_bitCnt <= '0;
      r_shift  <= '0;
    end else if (r_state == PUSH) begin
      r_bitCnt <= '0;
    end else if (w_sample) begin
      r_bitCnt <= r_bitCnt + CW'(1);
      if (MSB_FIRST != 0) r_shift <= {r_shift[DATA_W-2:0], r_sdH};
      else                r_shift <= {r_sdH, r_shift[DATA_W-1:1]};
    end
  end

  assign w_empty   = (r_wPtr == r_rPtr);
  assign w_full    = (r_wPtr[AW] != r_rPtr[AW]) && (r_wPtr[AW-1:0] == r_rPtr[AW-1:0]);
  assign w_pop     = ~w_empty & outReady;
  assign w_pushReq = (r_state == PUSH);
  // A same-cycle pop frees the slot, so a push into a full FIFO is then accepted.
  assign w_push    = w_pushReq & (~w_full | w_pop);
  assign w_setOv   = w_pushReq & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wPtr[AW-1:0]] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_wPtr     <= '0;
      r_rPtr     <= '0;
      r_overrun  <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      if (w_push) r_wPtr <= r_wPtr + (AW+1)'(1);
      if (w_pop)  r_rPtr <= r_rPtr + (AW+1)'(1);
      r_overrun  <= w_setOv | (r_overrun  & ~clrFlags);
      r_frameErr <= w_setFe | (r_frameErr & ~clrFlags);
    end
  end

  assign outValid  = ~w_empty;
  assign outData   = w_empty ? '0 : r_mem[r_rPtr[AW-1:0]];
  assign fillLevel = r_wPtr - r_rPtr;
  assign overrun   = r_overrun;
  assign frameErr  = r_frameErr;

endmodule

// File: tb/tb_spi_word_receiver.sv
// Randomized bench for spi_word_receiver: four instances (mode 0 MSB/LSB-first, mode 1,
// mode 3) see the same bit stream and are compared against a frame-level word queue model.
module tb_spi_word_receiver;

  logic clk = 1'b0, nRst = 1'b0, cs = 1'b0, base = 1'b0, sdi = 1'b0;
  logic outReady = 1'b0, clrFlags = 1'b0;
  logic sck0, sck1;
  logic [7:0] dat [4];
  logic       vld [4];
  logic       ovr [4];
  logic       fer [4];
  logic [2:0] fill [4];

  int nChecks = 0, nErrors = 0;
  logic [7:0] q[$];
  logic mOv = 1'b0, mFe = 1'b0;

  always #5 clk = ~clk;
  assign sck0 = base;
  assign sck1 = ~base;

  spi_word_receiver #(.DATA_W(8), .FIFO_DEPTH(4), .MSB_FIRST(1), .CPOL(0), .CPHA(0)) u_m0 (
    .clk(clk), .nRst(nRst), .cs(cs), .spiClk(sck0), .sdi(sdi), .outData(dat[0]),
    .outValid(vld[0]), .outReady(outReady), .overrun(ovr[0]), .frameErr(fer[0]),
    .clrFlags(clrFlags), .fillLevel(fill[0]));
  spi_word_receiver #(.DATA_W(8), .FIFO_DEPTH(4), .MSB_FIRST(0), .CPOL(0), .CPHA(0)) u_lsb (
    .clk(clk), .nRst(nRst), .cs(cs), .spiClk(sck0), .sdi(sdi), .outData(dat[1]),
    .outValid(vld[1]), .outReady(outReady), .overrun(ovr[1]), .frameErr(fer[1]),
    .clrFlags(clrFlags), .fillLevel(fill[1]));
  spi_word_receiver #(.DATA_W(8), .FIFO_DEPTH(4), .MSB_FIRST(1), .CPOL(1), .CPHA(1)) u_m3 (
    .clk(clk), .nRst(nRst), .cs(cs), .spiClk(sck1), .sdi(sdi), .outData(dat[2]),
    .outValid(vld[2]), .outReady(outReady), .overrun(ovr[2]), .frameErr(fer[2]),
    .clrFlags(clrFlags), .fillLevel(fill[2]));
  spi_word_receiver #(.DATA_W(8), .FIFO_DEPTH(4), .MSB_FIRST(1), .CPOL(0), .CPHA(1)) u_m1 (
    .clk(clk), .nRst(nRst), .cs(cs), .spiClk(sck0), .sdi(sdi), .outData(dat[3]),
    .outValid(vld[3]), .outReady(outReady), .overrun(ovr[3]), .frameErr(fer[3]),
    .clrFlags(clrFlags), .fillLevel(fill[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  // Instance 1 is LSB-first: the first bit on the wire lands in bit 0.
  function automatic logic [7:0] exp_word(input int d, input logic [7:0] w);
    return (d == 1) ? rev8(w) : w;
  endfunction

  // sdi is stable from 20ns before the leading edge to 20ns after the trailing edge.
  task automatic send_bit(input logic b);
    sdi = b;
    #20 base = 1'b1;
    #40 base = 1'b0;
    #20;
  endtask

  task automatic cs_begin();
    @(negedge clk);
    cs = 1'b1;
    #40;
  endtask

  task automatic cs_end();
    #40 cs = 1'b0;
    #100;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
    if (q.size() < 4) q.push_back(w);
    else              mOv = 1'b1;
  endtask

  task automatic send_partial(input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic check_status(input string tag);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s fill[%0d]", tag, d), 32'(fill[d]), 32'(q.size()));
      check($sformatf("%s valid[%0d]", tag, d), 32'(vld[d]), 32'(q.size() != 0));
      check($sformatf("%s overrun[%0d]", tag, d), 32'(ovr[d]), 32'(mOv));
      check($sformatf("%s frameErr[%0d]", tag, d), 32'(fer[d]), 32'(mFe));
    end
  endtask

  task automatic drain(input string tag);
    while (q.size() != 0) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        check($sformatf("%s data[%0d]", tag, d), 32'(dat[d]), 32'(exp_word(d, q[0])));
        check($sformatf("%s dvalid[%0d]", tag, d), 32'(vld[d]), 32'd1);
      end
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
      void'(q.pop_front());
    end
    @(negedge clk);
    check_status({tag, " drained"});
  endtask

  task automatic clear_flags();
    @(negedge clk);
    clrFlags = 1'b1;
    @(negedge clk);
    clrFlags = 1'b0;
    mOv = 1'b0;
    mFe = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, np;
    repeat (3) @(negedge clk);
    check_status("reset");
    for (int d = 0; d < 4; d++) check($sformatf("reset data[%0d]", d), 32'(dat[d]), 32'd0);
    nRst = 1'b1;
    repeat (5) @(negedge clk);

    cs_begin(); send_word(8'h9D); cs_end();
    check_status("w9D");
    drain("w9D");

    cs_begin(); send_word(8'hA5); send_word(8'h3C); cs_end();
    check_status("pair");
    drain("pair");

    cs_begin(); send_word(8'h5A); cs_end();
    check_status("w5A");
    drain("w5A");

    cs_begin();
    for (int i = 1; i <= 5; i++) send_word(8'(i));
    cs_end();
    check_status("overflow");
    drain("overflow");
    clear_flags();
    check_status("ovclr");

    cs_begin(); send_partial(5, 8'($urandom)); cs_end();
    mFe = 1'b1;
    cs_begin(); send_word(8'h77); cs_end();
    check_status("frame");
    drain("frame");
    clear_flags();
    check_status("feclr");

    cs_begin(); send_partial(4, 8'hFF);
    @(negedge clk);
    nRst = 1'b0;
    q.delete(); mOv = 1'b0; mFe = 1'b0;
    repeat (2) @(negedge clk);
    check_status("midrst");
    for (int d = 0; d < 4; d++) check($sformatf("midrst data[%0d]", d), 32'(dat[d]), 32'd0);
    nRst = 1'b1;
    send_partial(4, 8'hFF);
    cs_end();
    check_status("ignored");
    cs_begin(); send_word(8'h42); cs_end();
    check_status("w42");
    drain("w42");

    for (int f = 0; f < 40; f++) begin
      nw = int'($urandom_range(0, 3));
      np = ($urandom % 4 == 0) ? int'($urandom_range(1, 7)) : 0;
      if (nw == 0 && np == 0) nw = 1;
      cs_begin();
      for (int w = 0; w < nw; w++) send_word(8'($urandom));
      if (np > 0) send_partial(np, 8'($urandom));
      cs_end();
      if (np > 0) mFe = 1'b1;
      check_status($sformatf("rnd%0d", f));
      if ($urandom % 2 == 0) drain($sformatf("rnd%0d", f));
      if ($urandom % 3 == 0) clear_flags();
    end
    drain("final");

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
